// File: rtl/au_issue_pkg.sv
// rtl/au_issue_pkg.sv - shared types and constants for the arithmetic-unit command issuer
package au_issue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

    // One queued operation: 18 bits wide.
    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

endpackage

// File: rtl/au_cmd_issuer_if.sv
// rtl/au_cmd_issuer_if.sv - command, response and arithmetic-unit signals of the issuer
// master: front end plus arithmetic unit (drives commands, rsp_ready, au_result/au_done)
// slave : the issuer itself (drives cmd_ready, responses and the au_* controls)
interface au_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [1:0] rsp_op;
    logic       rsp_err;
    logic [7:0] au_a;
    logic [7:0] au_b;
    logic [1:0] au_op_select;
    logic       au_start;
    logic [7:0] au_result;
    logic       au_done;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, au_result, au_done,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err,
        input  au_a, au_b, au_op_select, au_start
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, au_result, au_done,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err,
        output au_a, au_b, au_op_select, au_start
    );
endinterface

// File: rtl/au_cmd_fifo.sv
// rtl/au_cmd_fifo.sv - synchronous DEPTH x 18-bit command FIFO with full/empty flags
// Ports: clk, rst (sync active-high), push/wdata, pop/rdata (show-ahead head), full, empty.
module au_cmd_fifo
    import au_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/au_cmd_issuer.sv
// rtl/au_cmd_issuer.sv - queues arithmetic-unit commands and issues them one at a time
// Optional feature macro: AU_DIV_ZERO_CHECK_EN (divide by zero answered locally, never issued).
// Ports: clk, rst (sync active-high), bus (au_cmd_issuer_if.slave):
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b     command port
//   rsp_valid/rsp_ready/rsp_result/rsp_op/rsp_err  response port, in command order
//   au_a/au_b/au_op_select/au_start, au_result/au_done  arithmetic unit side
module au_cmd_issuer
    import au_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 31
) (
    input logic            clk,
    input logic            rst,
    au_cmd_issuer_if.slave bus
);
    localparam int SW = (SETTLE  < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_d;
    cmd_t          head;
    cmd_t          cur;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          load_cur;
    logic          cap_done;
    logic          cap_timeout;
    logic          div_zero;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    rsp_result_q;
    logic [1:0]    rsp_op_q;
    logic          rsp_err_q;

    assign push = bus.cmd_valid && !full;

    au_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        load_cur    = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        div_zero    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    load_cur = 1'b1;
                    state_d  = ST_ISSUE;
`ifdef AU_DIV_ZERO_CHECK_EN
                    // Answer locally; the au_* operand registers keep their old values.
                    if (head.op == OP_DIV && head.b == 8'd0) begin
                        load_cur = 1'b0;
                        div_zero = 1'b1;
                        state_d  = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            // au_done is ignored here: it may still be high from the previous operation.
            ST_SETTLE: if (settle_cnt <= SW'(1)) state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.au_done) begin
                    cap_done = 1'b1;
                    state_d  = ST_RESP;
                end else if ((to_cnt + TW'(1)) == TW'(TIMEOUT)) begin
                    cap_timeout = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cur          <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state <= state_d;
            if (load_cur) cur <= head;
            if (state == ST_ISSUE) begin
                settle_cnt <= SW'(SETTLE);
                to_cnt     <= '0;
            end
            if (state == ST_SETTLE) settle_cnt <= settle_cnt - SW'(1);
            if (state == ST_WAIT && !bus.au_done) to_cnt <= to_cnt + TW'(1);
            if (cap_done) begin
                rsp_result_q <= bus.au_result;
                rsp_op_q     <= cur.op;
                rsp_err_q    <= 1'b0;
            end
            if (cap_timeout) begin
                rsp_result_q <= 8'd0;
                rsp_op_q     <= cur.op;
                rsp_err_q    <= 1'b1;
            end
            if (div_zero) begin
                rsp_result_q <= DIV_ZERO_RESULT;
                rsp_op_q     <= head.op;
                rsp_err_q    <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready    = !full;
    assign bus.rsp_valid    = (state == ST_RESP);
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_op       = rsp_op_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.au_a         = cur.a;
    assign bus.au_b         = cur.b;
    assign bus.au_op_select = cur.op;
    assign bus.au_start     = (state == ST_ISSUE);

endmodule

// File: doc/au_cmd_issuer.md
# au_cmd_issuer

- Command-side initiator for the 8-bit arithmetic unit (add/sub/restoring-div/mul).
- Accepts operation requests on a valid/ready command port and buffers them in a small FIFO.
- Issues them one at a time to the arithmetic unit's `start`/`op_select`/operand interface, waits for `done`, and returns each result in order on a valid/ready response port.
- Sits between the instruction/control front end and the arithmetic unit, replacing ad-hoc direct drive of `start`.

## Interface

Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `SETTLE`, 2: cycles after `au_start` during which `au_done` is ignored (covers stale `done` from the previous operation).
- `TIMEOUT`, 31: maximum cycles spent in WAIT before an error response is returned.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command FIFO not full
- `cmd_op`  in  2  00 add, 01 sub, 10 div, 11 mul
- `cmd_a`  in  8  operand a / dividend
- `cmd_b`  in  8  operand b / divisor
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed
- `rsp_result`  out  8  result (quotient for div)
- `rsp_op`  out  2  opcode of this response
- `rsp_err`  out  1  timeout or divide-by-zero
- `au_a`, `au_b`  out  8 each  operands to arithmetic unit
- `au_op_select`  out  2  operation to arithmetic unit
- `au_start`  out  1  one-cycle start pulse
- `au_result`  in  8  arithmetic unit result
- `au_done`  in  1  arithmetic unit done

## Operation

- Command push occurs when `cmd_valid && cmd_ready`.
- `cmd_ready = !full`. Push and pop in the same cycle leave the occupancy unchanged.
- FSM states: IDLE, ISSUE, SETTLE, WAIT, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head into the operand/op registers and go to ISSUE.
- **ISSUE:** `au_start=1` for exactly this cycle. Load the settle counter with SETTLE and the timeout counter with 0. Go to SETTLE.
- **SETTLE:** decrement the settle counter. `au_done` is ignored. Go to WAIT when the counter reaches 0.
- **WAIT:**
  - If `au_done=1`: capture `au_result` into `rsp_result`, set `rsp_err=0`, go to RESP.
  - Otherwise increment the timeout counter. When it equals TIMEOUT, set `rsp_result=0` and `rsp_err=1`, then go to RESP.
  - `au_done` takes priority over timeout in the same cycle.
- **RESP:** hold `rsp_valid=1` with stable `rsp_result`/`rsp_op`/`rsp_err` until `rsp_ready`. Go to IDLE on the handshake.
- `au_a`, `au_b` and `au_op_select` are registered. They are held from ISSUE through WAIT and keep their last values otherwise.
- Exactly one operation is outstanding at the arithmetic unit at any time.
- Responses are returned in command order.

## Timing

- Reset: state IDLE and FIFO empty. `cmd_ready=1`. The following outputs are all 0: `rsp_valid`, `rsp_result`, `rsp_op`, `rsp_err`, `au_a`, `au_b`, `au_op_select`, `au_start`.
- Reset mid-operation aborts the transaction: the FIFO is flushed, no response is produced, and `au_start` is 0 in the following cycle.
- Latency, with the command accepted at edge N into an empty FIFO while in IDLE:
  - pop at edge N+1;
  - `au_start` high in cycle N+2;
  - SETTLE occupies cycles N+3 to N+2+SETTLE;
  - first WAIT cycle is N+3+SETTLE.
  - If `au_done` is already high there, `rsp_valid` rises at cycle N+4+SETTLE (N+6 at default).
- Back-to-back: the next pop occurs at the edge after the response handshake.
- `rsp_ready` held low stalls the FSM in RESP. The FIFO keeps accepting commands until it is full.

## Configuration

- `AU_DIV_ZERO_CHECK_EN` defined: on pop, an op of 10 with b==0 is not issued. IDLE goes directly to RESP with `rsp_result=8'hFF` and `rsp_err=1`, and `au_start` is never pulsed.
- Not defined: divide-by-zero is issued like any other command, and the result is whatever the arithmetic unit returns (or the timeout response).

## Structure

- Package `au_issue_pkg` holds:
  - FSM state enum;
  - opcode constants `OP_ADD`/`OP_SUB`/`OP_DIV`/`OP_MUL`;
  - `DIV_ZERO_RESULT=8'hFF`;
  - command record type {op[1:0], a[7:0], b[7:0]}.
- Sub-module `au_cmd_fifo` is a synchronous FIFO of DEPTH x 18 bits with full/empty flags.
- The FSM, counters and response registers live in the top module.

## Test plan

- Single add: push a=8'd20, b=8'd22, op=00; model drives `au_done` high with `au_result=8'd42`. Expect `au_start` in cycle N+2, `rsp_valid` at N+6, result 42, err 0.
- Stale done: `au_done` held high continuously. Expect capture only in the first WAIT cycle, never in ISSUE/SETTLE. Response for sub 50−8 equals 42.
- Div latency: op=10, a=100, b=7; model raises `au_done` 9 cycles after `au_start` with result 14. Expect `rsp_result=14` and `au_start` pulsed exactly once.
- FIFO full/backpressure: push 5 commands with `rsp_ready=0`. Expect `cmd_ready` low after the 4th stored entry (DEPTH=4). Draining returns results in order.
- Timeout: `au_done` stuck 0. Expect `rsp_valid` with `rsp_result=0`, `rsp_err=1` after 31 WAIT cycles.
- Divide-by-zero and reset: with `AU_DIV_ZERO_CHECK_EN`, op=10, b=0 → `8'hFF`, err=1, no `au_start`. Separately, assert `rst` in WAIT → all outputs 0 next cycle and FIFO empty.
